// File: rtl/arb_rr8.sv
// 8-way round-robin arbiter with registered one-hot grant held until release.
// Optional hold-time limit enabled by defining ARB_TIMEOUT_EN (limit = MAX_HOLD cycles).
module arb_rr8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state, state_nxt;
  logic [7:0] grant_nxt;
  logic [2:0] idx_nxt;
  logic [2:0] last, last_nxt;
  logic       busy_nxt;
  logic       found;
  logic [2:0] cand;
  logic [2:0] winner;

  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
    $error("arb_rr8: MAX_HOLD must be in 2..256");
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt, hold_nxt;
  logic       timeout_nxt;
`endif

  // Search starts just after the most recent owner, wrapping modulo 8.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cand = last + 3'd1 + 3'(i);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    idx_nxt     = grant_idx;
    last_nxt    = last;
    busy_nxt    = busy;
`ifdef ARB_TIMEOUT_EN
    hold_nxt    = hold_cnt;
    timeout_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = BUSY;
          grant_nxt = 8'b1 << winner;
          idx_nxt   = winner;
          last_nxt  = winner;
          busy_nxt  = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_nxt  = '0;
`endif
        end
      end
      BUSY: begin
        if (!req[grant_idx]) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          busy_nxt  = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        // Release takes precedence over revoke on the same edge.
        else if (hold_cnt == 8'(MAX_HOLD - 1)) begin
          state_nxt   = IDLE;
          grant_nxt   = '0;
          busy_nxt    = 1'b0;
          timeout_nxt = 1'b1;
          last_nxt    = grant_idx;
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      last      <= 3'd7;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      grant_idx <= idx_nxt;
      last      <= last_nxt;
      busy      <= busy_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= hold_nxt;
      timeout  <= timeout_nxt;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_arb_rr8.sv
// Directed self-checking bench for arb_rr8; adapts the hold/timeout steps to ARB_TIMEOUT_EN.
module tb_arb_rr8;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned MAX_HOLD   = 4;
  localparam int unsigned HOLD_STEPS = 2;
`else
  localparam int unsigned MAX_HOLD   = 16;
  localparam int unsigned HOLD_STEPS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       busy;
  logic       timeout;

  int n_pass = 0;
  int n_total = 0;

  arb_rr8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rot_exp [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    #2;
    check("rst_grant", grant, 8'h00);
    check("rst_idx", {5'b0, grant_idx}, 8'h00);
    check("rst_busy", {7'b0, busy}, 8'h00);
    check("rst_timeout", {7'b0, timeout}, 8'h00);
    #1;
    rst_n = 1'b1;

    // single requester
    req = 8'h04;
    step();
    check("single_grant", grant, 8'h04);
    check("single_idx", {5'b0, grant_idx}, 8'h02);
    check("single_busy", {7'b0, busy}, 8'h01);
    req = 8'h00;
    step();
    check("single_drop", grant, 8'h00);
    check("single_drop_busy", {7'b0, busy}, 8'h00);
    check("single_idx_kept", {5'b0, grant_idx}, 8'h02);

    // reset priority then full rotation
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    req = 8'hFF;
    step();
    check("prio_first", grant, 8'h01);
    for (int k = 0; k < 8; k++) begin
      req = 8'hFF & ~grant;
      step();
      check("rot_gap", grant, 8'h00);
      req = 8'hFF;
      step();
      check("rot_grant", grant, rot_exp[k]);
    end
    req = 8'h00;
    step();

    // rotation skip: make 5 the last owner, then 0 must win over 5
    req = 8'h20;
    step();
    check("skip_setup", grant, 8'h20);
    req = 8'h00;
    step();
    req = 8'h21;
    step();
    check("skip_grant", grant, 8'h01);
    check("skip_idx", {5'b0, grant_idx}, 8'h00);
    req = 8'h00;
    step();

    // hold and ignore others
    req = 8'h08;
    step();
    check("hold_first", grant, 8'h08);
    req = 8'hFF;
    for (int unsigned k = 0; k < HOLD_STEPS; k++) begin
      step();
      check("hold_keep", grant, 8'h08);
      check("hold_timeout", {7'b0, timeout}, 8'h00);
    end
    req = 8'hF7;
    step();
    check("hold_release", grant, 8'h00);
    check("hold_release_busy", {7'b0, busy}, 8'h00);
    req = 8'hFF;
    step();
    check("hold_next", grant, 8'h10);
    check("hold_next_idx", {5'b0, grant_idx}, 8'h04);

    // async reset mid-grant
    #2 rst_n = 1'b0;
    #1;
    check("async_grant", grant, 8'h00);
    check("async_busy", {7'b0, busy}, 8'h00);
    check("async_timeout", {7'b0, timeout}, 8'h00);
    check("async_idx", {5'b0, grant_idx}, 8'h00);
    rst_n = 1'b1;
    step();
    check("async_prio", grant, 8'h01);

    // hold limit
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    req = 8'h03;
    step();
    check("to_first", grant, 8'h01);
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      step();
      check("to_hold", grant, 8'h01);
      check("to_no_pulse", {7'b0, timeout}, 8'h00);
    end
    step();
    check("to_revoke", grant, 8'h00);
    check("to_revoke_busy", {7'b0, busy}, 8'h00);
    check("to_pulse", {7'b0, timeout}, 8'h01);
    step();
    check("to_next", grant, 8'h02);
    check("to_next_idx", {5'b0, grant_idx}, 8'h01);
    check("to_pulse_end", {7'b0, timeout}, 8'h00);
`else
    for (int k = 0; k < 20; k++) begin
      step();
      check("nolimit_hold", grant, 8'h01);
      check("nolimit_timeout", {7'b0, timeout}, 8'h00);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
